// File: rtl/jtdsp16_defs.sv
// ---------------------------------------------------------------------------
// jtdsp16_defs
// Shared definitions for the interrupt/trap sequencer of the XAAU.
//   state_t : sequencer state encoding (RUN / ISR_IRQ / ISR_TRAP)
//   GAP_W   : width of the post-iret re-arm gap counter
// ---------------------------------------------------------------------------
package jtdsp16_defs;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_ISR_IRQ  = 2'd1,
    ST_ISR_TRAP = 2'd2
  } state_t;

  localparam int GAP_W = 2;

endpackage

// File: rtl/jtdsp16_sync.sv
// ---------------------------------------------------------------------------
// jtdsp16_sync
// Multi-stage synchroniser for an asynchronous pin, with a rising-edge pulse.
// Runs on every clk (no clock enable) so short pulses are never missed.
//   clk  : system clock
//   rst  : asynchronous reset, active high
//   din  : asynchronous input
//   sync : synchronised level (last synchroniser stage)
//   rise : one-clk pulse when the synchronised level goes 0 -> 1
// ---------------------------------------------------------------------------
module jtdsp16_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise
);

  // chain_r[STAGES-1] is the synchronised level; chain_r[STAGES] is its
  // previous value, kept only for edge detection.
  logic [STAGES:0] chain_r;

  // Shift the pin through the synchroniser and edge-history stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_r <= {(STAGES+1){1'b0}};
    end else begin
      chain_r <= {chain_r[STAGES-1:0], din};
    end
  end

  assign sync = chain_r[STAGES-1];
  assign rise = chain_r[STAGES-1] & ~chain_r[STAGES];

endmodule

// File: rtl/jtdsp16_irq_seq.sv
// ---------------------------------------------------------------------------
// jtdsp16_irq_seq
// Interrupt/trap sequencer for the ROM address arithmetic unit (XAAU).
// Latches external requests, picks the instruction boundary at which the PC
// is redirected, and freezes PI while a service routine (IRQ or trap) runs.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   cen       : instruction-rate enable; FSM and gap counter advance only here
//   irq_pin   : asynchronous external request
//   irq_en    : interrupt enable (masks entry only)
//   no_int    : current instruction not interruptible
//   icall     : trap instruction executing this cen cycle
//   iret      : ireturn executing this cen cycle
//   ext_irq   : force PC to 0 this cen cycle (combinational)
//   shadow    : 1 = normal execution, 0 = inside a service routine
//   iack      : high from IRQ entry until its iret (not for traps)
//   irq_pend  : request latched, not yet serviced
// ---------------------------------------------------------------------------
module jtdsp16_irq_seq
  import jtdsp16_defs::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TRIG   = 1,
  parameter int REARM_GAP   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic cen,
  input  logic irq_pin,
  input  logic irq_en,
  input  logic no_int,
  input  logic icall,
  input  logic iret,
  output logic ext_irq,
  output logic shadow,
  output logic iack,
  output logic irq_pend
);

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(REARM_GAP);
  localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
  localparam logic [GAP_W-1:0] GAP_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_nxt;
  logic [GAP_W-1:0] gap_r;
  logic [GAP_W-1:0] gap_nxt;
  logic             pend_r;
  logic             pend_nxt;
  logic             shadow_r;
  logic             iack_r;
  logic             pin_sync;
  logic             pin_rise;
  logic             req_set;
  logic             take_irq;

  jtdsp16_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (irq_pin),
    .sync (pin_sync),
    .rise (pin_rise)
  );

  assign req_set = (EDGE_TRIG != 0) ? pin_rise : pin_sync;

  // Entry qualification, next state, gap counter and pending request.
  always_comb begin
    state_nxt = state_r;
    gap_nxt   = gap_r;
    take_irq  = cen & (state_r == ST_RUN) & pend_r & irq_en & ~no_int
              & ~icall & (gap_r == GAP_ZERO);
    // A new request in the same clk as entry wins over the clear.
    pend_nxt  = req_set | (pend_r & ~take_irq);
    if (cen) begin
      case (state_r)
        ST_RUN: begin
          // The trap has priority; take_irq already excludes icall.
          if (icall) begin
            state_nxt = ST_ISR_TRAP;
          end else if (take_irq) begin
            state_nxt = ST_ISR_IRQ;
          end else begin
            state_nxt = ST_RUN;
          end
        end
        ST_ISR_IRQ, ST_ISR_TRAP: begin
          // icall inside a routine is ignored: no nesting.
          if (iret) begin
            state_nxt = ST_RUN;
          end else begin
            state_nxt = state_r;
          end
        end
        default: begin
          state_nxt = ST_RUN;
        end
      endcase
      if ((state_r != ST_RUN) && iret) begin
        gap_nxt = GAP_LOAD;
      end else if (gap_r != GAP_ZERO) begin
        gap_nxt = gap_r - GAP_ONE;
      end else begin
        gap_nxt = gap_r;
      end
    end else begin
      state_nxt = state_r;
      gap_nxt   = gap_r;
    end
  end

  // Sequencer state and registered XAAU/pin outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_RUN;
      gap_r    <= GAP_ZERO;
      pend_r   <= 1'b0;
      shadow_r <= 1'b1;
      iack_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      gap_r    <= gap_nxt;
      pend_r   <= pend_nxt;
      shadow_r <= (state_nxt == ST_RUN);
      iack_r   <= (state_nxt == ST_ISR_IRQ);
    end
  end

  assign ext_irq  = take_irq;
  assign shadow   = shadow_r;
  assign iack     = iack_r;
  assign irq_pend = pend_r;

endmodule

// File: tb/tb_jtdsp16_irq_seq.sv
// ---------------------------------------------------------------------------
// tb_jtdsp16_irq_seq
// Directed scenarios followed by randomized traffic, all compared cycle by
// cycle against a behavioural model of the sequencer.
// ---------------------------------------------------------------------------
module tb_jtdsp16_irq_seq;

  localparam int SYNC_STAGES = 2;
  localparam int EDGE_TRIG   = 1;
  localparam int REARM_GAP   = 1;

  logic clk = 1'b0;
  logic rst, cen, irq_pin, irq_en, no_int, icall, iret;
  logic ext_irq, shadow, iack, irq_pend;

  int checks   = 0;
  int failures = 0;
  int ext_seen = 0;

  // Behavioural model: pin history (index 0 = newest sample), pending flag,
  // "inside a routine" flag, kind of routine and remaining re-arm gap.
  bit pin_q[$];
  bit m_pend;
  bit m_in_isr;
  bit m_is_irq;
  int m_gap;

  always #5 clk = ~clk;

  jtdsp16_irq_seq #(
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TRIG   (EDGE_TRIG),
    .REARM_GAP   (REARM_GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .irq_pin  (irq_pin),
    .irq_en   (irq_en),
    .no_int   (no_int),
    .icall    (icall),
    .iret     (iret),
    .ext_irq  (ext_irq),
    .shadow   (shadow),
    .iack     (iack),
    .irq_pend (irq_pend)
  );

  task automatic check_bit(input string tag, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b time=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pin_q.delete();
    for (int i = 0; i < SYNC_STAGES + 2; i++) pin_q.push_back(1'b0);
    m_pend   = 1'b0;
    m_in_isr = 1'b0;
    m_is_irq = 1'b0;
    m_gap    = 0;
  endtask

  function automatic bit m_ext();
    return cen && !m_in_isr && m_pend && irq_en && !no_int && !icall && (m_gap == 0);
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit ext;
    bit set;
    ext = m_ext();
    pin_q.push_front(irq_pin);
    // A pin sample becomes a request SYNC_STAGES edges later.
    if (EDGE_TRIG != 0) set = pin_q[SYNC_STAGES] && !pin_q[SYNC_STAGES+1];
    else                set = pin_q[SYNC_STAGES];
    void'(pin_q.pop_back());
    m_pend = set || (m_pend && !ext);
    if (cen) begin
      if (!m_in_isr) begin
        if (icall) begin
          m_in_isr = 1'b1;
          m_is_irq = 1'b0;
        end else if (ext) begin
          m_in_isr = 1'b1;
          m_is_irq = 1'b1;
        end
        if (m_gap > 0) m_gap--;
      end else if (iret) begin
        m_in_isr = 1'b0;
        m_gap    = REARM_GAP;
      end
    end
  endtask

  task automatic drive(input bit c, input bit p, input bit en, input bit ni,
                       input bit ic, input bit ir);
    cen = c; irq_pin = p; irq_en = en; no_int = ni; icall = ic; iret = ir;
  endtask

  // One clock: compare on the falling edge, update the model on the rising edge.
  task automatic tick();
    @(negedge clk);
    if (ext_irq === 1'b1) ext_seen++;
    check_bit("ext_irq",  ext_irq,  m_ext());
    check_bit("shadow",   shadow,   !m_in_isr);
    check_bit("iack",     iack,     m_in_isr && m_is_irq);
    check_bit("irq_pend", irq_pend, m_pend);
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  // Pulse irq_pin for one clk, then idle n clks with cen low (request settles).
  task automatic pulse_and_settle(input int n, input bit ni);
    drive(1'b0, 1'b1, 1'b1, ni, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b1, ni, 1'b0, 1'b0);
      tick();
    end
  endtask

  int base;

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_bit("rst_shadow",   shadow,   1'b1);
    check_bit("rst_iack",     iack,     1'b0);
    check_bit("rst_irq_pend", irq_pend, 1'b0);
    check_bit("rst_ext_irq",  ext_irq,  1'b0);
    rst = 1'b0;

    // 1: one-clk pulse, cen every other clk.
    base = ext_seen;
    for (int c = 0; c < 12; c++) begin
      drive(c[0], c == 0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    check_bit("t1_one_entry", ext_seen == base + 1, 1'b1);
    check_bit("t1_iack",      iack,   1'b1);
    check_bit("t1_shadow",    shadow, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick(); end

    // 2: pending held off by no_int for three cen cycles.
    pulse_and_settle(3, 1'b1);
    base = ext_seen;
    for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick(); end
    check_bit("t2_held_off", ext_seen == base, 1'b1);
    for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick(); end
    check_bit("t2_one_entry", ext_seen == base + 1, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick(); end

    // 3: icall beats a pending IRQ; gap of one cen after iret.
    pulse_and_settle(3, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    check_bit("t3_iack",   iack,     1'b0);
    check_bit("t3_shadow", shadow,   1'b0);
    check_bit("t3_pend",   irq_pend, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    base = ext_seen;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    check_bit("t3_gap_blocks", ext_seen == base, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    check_bit("t3_reentry", ext_seen == base + 1, 1'b1);

    // 4: second edge while in ISR_IRQ, serviced after iret + gap.
    pulse_and_settle(3, 1'b0);
    base = ext_seen;
    for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick(); end
    check_bit("t4_no_nest", ext_seen == base, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick(); end
    check_bit("t4_reentry", ext_seen == base + 1, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    for (int i = 0; i < 2; i++) begin drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick(); end

    // 5: masked for ten cen cycles, then enabled.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    base = ext_seen;
    for (int i = 0; i < 12; i++) begin drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick(); end
    check_bit("t5_masked", ext_seen == base, 1'b1);
    check_bit("t5_pend",   irq_pend, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    check_bit("t5_entry", ext_seen == base + 1, 1'b1);

    // 6: reset in ISR_IRQ with a request pending.
    pulse_and_settle(3, 1'b0);
    check_bit("t6_pre_pend", irq_pend, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_bit("t6_shadow",  shadow,   1'b1);
    check_bit("t6_iack",    iack,     1'b0);
    check_bit("t6_pend",    irq_pend, 1'b0);
    check_bit("t6_ext_irq", ext_irq,  1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    pulse_and_settle(3, 1'b0);
    base = ext_seen;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    check_bit("t6_resume", ext_seen == base + 1, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      irq_pin = ($urandom_range(0, 7) == 0) ? ~irq_pin : irq_pin;
      cen     = ($urandom_range(0, 2) != 0);
      irq_en  = ($urandom_range(0, 7) != 0);
      no_int  = ($urandom_range(0, 4) == 0);
      icall   = ($urandom_range(0, 11) == 0);
      iret    = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
